// File: rtl/uart_rx_frame_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_if
// Purpose  : Bundle of the UART receiver's line and consumer signals.
//            slave  modport -> receiver side (drives byte/flags)
//            master modport -> line driver / byte consumer side
// Signals  : RX       serial line, idles high
//            clr_rdy  consumer acknowledge, clears rdy
//            rx_data  last good received byte
//            rdy      sticky byte-waiting flag
//            frm_err  1-cycle pulse, stop bit sampled low
//            ovr      1-cycle pulse, good byte completed while rdy still high
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_frame_if;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr;

  modport slave  (input RX, clr_rdy, output rx_data, rdy, frm_err, ovr);
  modport master (output RX, clr_rdy, input rx_data, rdy, frm_err, ovr);
endinterface
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame
// Purpose  : 8N1 UART receiver. Synchronises RX, detects the start edge,
//            samples each bit mid-cell with a baud counter and presents the
//            byte with a sticky rdy flag, plus framing/overrun pulses.
// Ports    : clk    system clock
//            rst_n  asynchronous active-low reset
//            bus    uart_rx_frame_if.slave (RX, clr_rdy in; rx_data, rdy,
//                   frm_err, ovr out)
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame #(
  parameter int BAUD_DIV = 2604
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  uart_rx_frame_if.slave  bus
);

  localparam logic [11:0] c_HALF   = 12'(BAUD_DIV / 2);
  localparam logic [11:0] c_RELOAD = 12'(BAUD_DIV - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RCV  = 1'b1
  } state_t;

  // Synchroniser and edge history; all reset high so reset never looks like a start
  logic r_rx_meta;
  logic r_rx_s;
  logic r_rx_prev;

  state_t      r_state,    w_state_nxt;
  logic [11:0] r_baud_cnt, w_baud_nxt;
  logic [3:0]  r_bit_cnt,  w_bit_nxt;
  logic [8:0]  r_shift,    w_shift_nxt;
  logic [7:0]  r_rx_data,  w_data_nxt;
  logic        r_rdy,      w_rdy_nxt;
  logic        r_frm_err,  w_frm_nxt;
  logic        r_ovr,      w_ovr_nxt;

  logic w_start;
  // Sample 0 (start bit) is shifted in too and falls off the LSB unused
  logic w_unused;

  assign w_start  = r_rx_prev & ~r_rx_s;
  assign w_unused = r_shift[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta  <= 1'b1;
      r_rx_s     <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_state    <= S_IDLE;
      r_baud_cnt <= 12'd0;
      r_bit_cnt  <= 4'd0;
      r_shift    <= 9'd0;
      r_rx_data  <= 8'h00;
      r_rdy      <= 1'b0;
      r_frm_err  <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_rx_meta  <= bus.RX;
      r_rx_s     <= r_rx_meta;
      r_rx_prev  <= r_rx_s;
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_rx_data  <= w_data_nxt;
      r_rdy      <= w_rdy_nxt;
      r_frm_err  <= w_frm_nxt;
      r_ovr      <= w_ovr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_rx_data;
    // Consumer clear is the default; frame start and completion override it
    w_rdy_nxt   = r_rdy & ~bus.clr_rdy;
    w_frm_nxt   = 1'b0;
    w_ovr_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_baud_nxt  = c_HALF;
          w_bit_nxt   = 4'd0;
          w_rdy_nxt   = 1'b0;   // a new frame invalidates the old byte
          w_state_nxt = S_RCV;
        end
      end

      S_RCV: begin
        if (r_baud_cnt == 12'd0) begin
          w_baud_nxt  = c_RELOAD;
          w_shift_nxt = {r_rx_s, r_shift[8:1]};
          if (r_bit_cnt != 4'd9) begin
            w_bit_nxt = r_bit_cnt + 4'd1;
          end
          if ((r_bit_cnt == 4'd0) && r_rx_s) begin
            // Start bit high at mid-cell: line glitch, drop silently
            w_state_nxt = S_IDLE;
          end else if (r_bit_cnt == 4'd9) begin
            w_state_nxt = S_IDLE;
            if (r_rx_s) begin
              // r_shift[8:1] holds data bits 7..0; set wins over clr_rdy
              w_data_nxt = r_shift[8:1];
              w_rdy_nxt  = 1'b1;
              w_ovr_nxt  = r_rdy & ~bus.clr_rdy;
            end else begin
              w_frm_nxt = 1'b1;
            end
          end
        end else begin
          w_baud_nxt = r_baud_cnt - 12'd1;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.rx_data = r_rx_data;
  assign bus.rdy     = r_rdy;
  assign bus.frm_err = r_frm_err;
  assign bus.ovr     = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_frame
// Purpose  : Self-checking bench for uart_rx_frame at BAUD_DIV=16. Drives
//            directed and random 8N1 frames and compares against a
//            frame-level reference model of byte, rdy and flag counts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame;

  localparam int c_DIV = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_rx_frame_if bus ();

  uart_rx_frame #(.BAUD_DIV(c_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Observed event counters, sampled on the falling edge
  int   cyc      = 0;
  int   n_frm    = 0;
  int   n_ovr    = 0;
  int   n_rise   = 0;
  int   rise_cyc = -1;
  logic rdy_q    = 1'b0;
  int   start_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.frm_err === 1'b1) n_frm++;
    if (bus.ovr === 1'b1) n_ovr++;
    if (bus.rdy === 1'b1 && rdy_q !== 1'b1) begin
      n_rise++;
      rise_cyc = cyc;
    end
    rdy_q = bus.rdy;
  end

  // Reference model: frame-level effect on byte, rdy and flag counts
  logic [7:0] exp_data = 8'h00;
  logic       exp_rdy  = 1'b0;
  int         exp_frm  = 0;
  int         exp_ovr  = 0;
  int         exp_rise = 0;

  task automatic model_frame(input logic [7:0] b, input bit stop,
                             input bit rdy_before_end, input bit clr_held);
    if (stop) begin
      if (rdy_before_end && !clr_held) exp_ovr++;
      exp_data = b;
      exp_rise++;
      exp_rdy  = !clr_held;
    end else begin
      exp_frm++;
      exp_rdy = rdy_before_end && !clr_held;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".rx_data"}, 32'(bus.rx_data), 32'(exp_data));
    check({tag, ".rdy"},     32'(bus.rdy),     32'(exp_rdy));
    check({tag, ".n_frm"},   32'(n_frm),       32'(exp_frm));
    check({tag, ".n_ovr"},   32'(n_ovr),       32'(exp_ovr));
    check({tag, ".n_rise"},  32'(n_rise),      32'(exp_rise));
  endtask

  task automatic idle(input int n);
    bus.RX = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Caller must be on a falling edge. Leaves RX at the stop level.
  task automatic send_frame(input logic [7:0] b, input bit stop, input int stop_len,
                            input bit chk_mid, input bit inject);
    bus.RX    = 1'b0;
    start_cyc = cyc;
    repeat (c_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.RX = b[i];
      if (i == 4 && chk_mid) check("mid_frame_rdy", 32'(bus.rdy), 32'd0);
      if (i == 5 && inject) begin
        force dut.r_rdy = 1'b1;
        @(negedge clk);
        release dut.r_rdy;
        repeat (c_DIV - 1) @(negedge clk);
      end else begin
        repeat (c_DIV) @(negedge clk);
      end
    end
    bus.RX = stop;
    repeat (stop_len) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    bit         stp;
    int         lat;

    rst_n       = 1'b0;
    bus.RX      = 1'b1;
    bus.clr_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check_state("reset");
    rst_n = 1'b1;
    idle(5);

    // 1: basic byte and start-edge-to-rdy latency
    send_frame(8'h67, 1'b1, c_DIV, 1'b1, 1'b0);
    model_frame(8'h67, 1'b1, 1'b0, 1'b0);
    lat = rise_cyc - start_cyc;
    check("latency_in_window", 32'(lat >= 155 && lat <= 157), 32'd1);
    idle(4);
    check_state("t1_0x67");

    // 2: single-cycle clear, then clear while already clear
    bus.clr_rdy = 1'b1;
    @(negedge clk);
    bus.clr_rdy = 1'b0;
    exp_rdy = 1'b0;
    check_state("t2_clr");
    bus.clr_rdy = 1'b1;
    @(negedge clk);
    bus.clr_rdy = 1'b0;
    @(negedge clk);
    check_state("t2_clr_noop");

    // 3: 4-cycle glitch is rejected, following byte arrives
    bus.RX = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    check_state("t3_glitch");
    send_frame(8'h73, 1'b1, c_DIV, 1'b1, 1'b0);
    model_frame(8'h73, 1'b1, 1'b0, 1'b0);
    idle(4);
    check_state("t3_0x73");

    // 4: framing error
    send_frame(8'h55, 1'b0, c_DIV, 1'b1, 1'b0);
    model_frame(8'h55, 1'b0, 1'b0, 1'b0);
    idle(4);
    check_state("t4_frm_err");

    // 5a: back-to-back, second start one cycle after the stop sample
    send_frame(8'h67, 1'b1, 10, 1'b1, 1'b0);
    model_frame(8'h67, 1'b1, 1'b0, 1'b0);
    send_frame(8'h73, 1'b1, c_DIV, 1'b1, 1'b0);
    model_frame(8'h73, 1'b1, 1'b0, 1'b0);
    idle(4);
    check_state("t5_b2b");

    // 5b: completion while rdy is artificially high -> overrun
    send_frame(8'hC9, 1'b1, c_DIV, 1'b1, 1'b1);
    model_frame(8'hC9, 1'b1, 1'b1, 1'b0);
    idle(4);
    check_state("t5_ovr");

    // clr_rdy held high through a frame: set wins, then cleared
    bus.clr_rdy = 1'b1;
    send_frame(8'h9E, 1'b1, c_DIV, 1'b1, 1'b0);
    model_frame(8'h9E, 1'b1, 1'b0, 1'b1);
    idle(4);
    bus.clr_rdy = 1'b0;
    check_state("clr_held");

    // Break: line held low for many bit times -> one framing error only
    bus.RX = 1'b0;
    start_cyc = cyc;
    repeat (15 * c_DIV) @(negedge clk);
    exp_frm++;
    exp_rdy = 1'b0;
    check_state("break_low");
    idle(20);
    check_state("break_release");

    // Random frames with random stop bits and random consumer clears
    for (int k = 0; k < 8; k++) begin
      b   = 8'($urandom);
      stp = ($urandom_range(0, 3) != 0);
      send_frame(b, stp, c_DIV, 1'b1, 1'b0);
      model_frame(b, stp, 1'b0, 1'b0);
      idle(5);
      check_state("rand_frame");
      if ($urandom_range(0, 1) == 1) begin
        bus.clr_rdy = 1'b1;
        @(negedge clk);
        bus.clr_rdy = 1'b0;
        exp_rdy = 1'b0;
        check("rand_clr_rdy", 32'(bus.rdy), 32'd0);
      end
    end

    // 6: reset during data bit 4 of 0xA5, then receive 0x3C
    b = 8'hA5;
    bus.RX = 1'b0;
    repeat (c_DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.RX = b[i];
      repeat (c_DIV) @(negedge clk);
    end
    bus.RX = b[4];
    repeat (c_DIV / 2) @(negedge clk);
    rst_n  = 1'b0;
    bus.RX = 1'b1;
    #1;
    exp_data = 8'h00;
    exp_rdy  = 1'b0;
    check("t6_rst.rx_data", 32'(bus.rx_data), 32'd0);
    check("t6_rst.rdy",     32'(bus.rdy),     32'd0);
    check("t6_rst.frm_err", 32'(bus.frm_err), 32'd0);
    check("t6_rst.ovr",     32'(bus.ovr),     32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    check_state("t6_after_rst");
    send_frame(8'h3C, 1'b1, c_DIV, 1'b1, 1'b0);
    model_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    idle(4);
    check_state("t6_0x3C");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
